// File: rtl/sdram_stream_reader.sv
// Streams a contiguous run of SDRAM words into a first-word fall-through FIFO,
// splitting the run into row-bounded, FIFO-safe read bursts.
module sdram_stream_reader #(
  parameter int FIFO_DEPTH = 512,
  parameter int BURST_MAX  = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [22:0] start_address,
  input  logic [15:0] word_count,
  output logic        busy,
  output logic        done,
  output logic        rd_request,
  output logic [22:0] rd_address,
  output logic [8:0]  rd_burst_length,
  input  logic        rd_available,
  input  logic [31:0] rd_data,
  output logic        out_valid,
  output logic [31:0] out_data,
  input  logic        out_ready
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [8:0] BMAX = 9'(BURST_MAX);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_DATA
  } state_t;

  state_t      state;
  logic [22:0] addr;
  logic [15:0] remaining;
  logic [8:0]  rcv_cnt;

  logic [31:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;

  logic [8:0]    row_left;
  logic [8:0]    lim;
  logic [8:0]    n;
  logic [8:0]    n_done;
  logic [CW-1:0] free;
  logic          space_ok;
  logic          push;
  logic          pop;
  logic          last_beat;
  logic          unused_addr_lsb;

  assign unused_addr_lsb = ^start_address[1:0];

  // Burst size: bounded by what is left, the burst limit and the row end.
  always_comb begin
    row_left  = 9'd256 - {1'b0, addr[9:2]};
    lim       = (row_left < BMAX) ? row_left : BMAX;
    n         = (remaining < {7'd0, lim}) ? remaining[8:0] : lim;
    free      = CW'(FIFO_DEPTH) - count;
    space_ok  = 32'(free) >= 32'(n);
    n_done    = rd_burst_length + 9'd1;
    push      = (state == WAIT_DATA) && rd_available;
    last_beat = push && (rcv_cnt == rd_burst_length);
    pop       = out_valid && out_ready;
  end

  assign out_valid = (count != '0);
  assign out_data  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= rd_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      busy            <= 1'b0;
      done            <= 1'b0;
      rd_request      <= 1'b0;
      rd_address      <= '0;
      rd_burst_length <= '0;
      addr            <= '0;
      remaining       <= '0;
      rcv_cnt         <= '0;
    end else begin
      done       <= 1'b0;
      rd_request <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (word_count != 16'd0) begin
              addr      <= {start_address[22:2], 2'b00};
              remaining <= word_count;
              busy      <= 1'b1;
              state     <= ISSUE;
            end else begin
              done <= 1'b1;
            end
          end
        end
        ISSUE: begin
          if (space_ok) begin
            rd_address      <= addr;
            rd_burst_length <= n - 9'd1;
            rd_request      <= 1'b1;
            rcv_cnt         <= '0;
            state           <= WAIT_DATA;
          end
        end
        WAIT_DATA: begin
          if (push) begin
            rcv_cnt <= rcv_cnt + 9'd1;
          end
          if (last_beat) begin
            addr      <= addr + {12'd0, n_done, 2'b00};
            remaining <= remaining - {7'd0, n_done};
            if (remaining == {7'd0, n_done}) begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= IDLE;
            end else begin
              state <= ISSUE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_stream_reader.sv
// Bench for sdram_stream_reader: controller/memory model, consumer and
// a run-level reference that derives bursts and word order from address rules.
module tb_sdram_stream_reader;

  localparam int DEPTH = 128;
  localparam int BMAX  = 64;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [22:0] start_address;
  logic [15:0] word_count;
  logic        busy;
  logic        done;
  logic        rd_request;
  logic [22:0] rd_address;
  logic [8:0]  rd_burst_length;
  logic        rd_available;
  logic [31:0] rd_data;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_ready;

  sdram_stream_reader #(
    .FIFO_DEPTH(DEPTH),
    .BURST_MAX (BMAX)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .start_address  (start_address),
    .word_count     (word_count),
    .busy           (busy),
    .done           (done),
    .rd_request     (rd_request),
    .rd_address     (rd_address),
    .rd_burst_length(rd_burst_length),
    .rd_available   (rd_available),
    .rd_data        (rd_data),
    .out_valid      (out_valid),
    .out_data       (out_data),
    .out_ready      (out_ready)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [22:0] a;
    logic [8:0]  l;
  } burst_t;

  typedef struct {
    logic [22:0] a;
    int          cnt;
    int          mode;
    int          nb;
    int          fl;
  } vec_t;

  int chk_cnt = 0;
  int pass_cnt = 0;
  int cyc = 0;
  int strobes = 0;
  int req_count = 0;
  int first_len = -1;
  int last_strobe_cyc = 0;
  int ready_mode = 0;

  burst_t      exp_bursts[$];
  logic [31:0] exp_words[$];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] pat(input logic [20:0] w);
    return ({11'd0, w} * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)",
                  name, act, exp, cyc);
  endtask

  task automatic fail(input string name, input string what);
    chk_cnt++;
    $display("FAIL %s: %s (cycle %0d)", name, what, cyc);
  endtask

  // Reference: expected bursts and word stream of one run.
  task automatic model_run(input logic [22:0] sa, input int cnt);
    logic [22:0] a;
    logic [20:0] w;
    int rem, col, n;
    burst_t b;
    a = {sa[22:2], 2'b00};
    for (int i = 0; i < cnt; i++) begin
      w = a[22:2] + 21'(i);
      exp_words.push_back(pat(w));
    end
    rem = cnt;
    while (rem > 0) begin
      col = int'(a[9:2]);
      n = rem;
      if (n > BMAX) n = BMAX;
      if (n > 256 - col) n = 256 - col;
      b.a = a;
      b.l = 9'(n - 1);
      exp_bursts.push_back(b);
      a = a + 23'(4 * n);
      rem -= n;
    end
  endtask

  // SDRAM controller and memory model.
  initial begin
    int pending;
    int idx;
    logic [22:0] base;
    logic [8:0] blen;
    logic rs;
    burst_t b;
    pending = 0;
    idx = 0;
    base = '0;
    blen = '0;
    rd_available = 1'b0;
    rd_data = '0;
    forever begin
      @(posedge clk);
      rs = reset;
      #1;
      if (rs) begin
        pending = 0;
        rd_available = 1'b0;
      end else begin
        if (rd_request) begin
          chk("req_while_busy", 32'(pending), 32'd0);
          req_count++;
          if (req_count == 1) first_len = int'(rd_burst_length);
          if (exp_bursts.size() == 0) begin
            fail("unexpected_req",
                 $sformatf("got request addr %h, required none", rd_address));
          end else begin
            b = exp_bursts.pop_front();
            chk("req_addr", 32'(rd_address), 32'(b.a));
            chk("req_len", 32'(rd_burst_length), 32'(b.l));
          end
          base = rd_address;
          blen = rd_burst_length;
          idx = 0;
          pending = int'(rd_burst_length) + 1;
        end
        if (pending > 0 && $urandom_range(3) != 0) begin
          chk("addr_stable", 32'(rd_address), 32'(base));
          chk("len_stable", 32'(rd_burst_length), 32'(blen));
          rd_available = 1'b1;
          rd_data = pat(base[22:2] + 21'(idx));
          idx++;
          pending--;
          strobes++;
          last_strobe_cyc = cyc;
        end else if (pending == 0 && $urandom_range(4) == 0) begin
          rd_available = 1'b1;
          rd_data = 32'hBAD0_0000 ^ $urandom;
        end else begin
          rd_available = 1'b0;
        end
      end
    end
  end

  // Consumer: decides ready at negedge and checks the word it will pop.
  initial begin
    logic [31:0] e;
    out_ready = 1'b0;
    forever begin
      @(negedge clk);
      case (ready_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'($urandom_range(1));
        default: out_ready = 1'b0;
      endcase
      if (out_valid && out_ready && !reset) begin
        if (exp_words.size() == 0) begin
          fail("extra_word", $sformatf("got %h, required none", out_data));
        end else begin
          e = exp_words.pop_front();
          chk("out_data", out_data, e);
        end
      end
    end
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: got no finish, required finish before 3ms");
    $fatal(1, "watchdog");
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [22:0] sa, input int cnt);
    model_run(sa, cnt);
    strobes = 0;
    req_count = 0;
    first_len = -1;
    start = 1'b1;
    start_address = sa;
    word_count = 16'(cnt);
    cycles(1);
    start = 1'b0;
    start_address = 23'($urandom);
    word_count = 16'($urandom);
    if (cnt != 0) begin
      chk("busy_after_start", 32'(busy), 32'd1);
    end else begin
      chk("done_zero", 32'(done), 32'd1);
      chk("busy_zero", 32'(busy), 32'd0);
    end
  endtask

  task automatic poke_start();
    start = 1'b1;
    start_address = 23'h000040;
    word_count = 16'd5;
    cycles(1);
    start = 1'b0;
  endtask

  task automatic finish_run(input int cnt);
    int t;
    bit got;
    t = 0;
    got = 0;
    if (cnt == 0) begin
      cycles(1);
      chk("zero_done_pulse", 32'(done), 32'd0);
      cycles(3);
      chk("zero_no_req", 32'(req_count), 32'd0);
      return;
    end
    while (t < 8000 && !got) begin
      if (done) got = 1;
      else begin
        cycles(1);
        t++;
      end
    end
    if (!got) begin
      fail("done_timeout", "got no done, required done");
    end else begin
      chk("done_strobes", 32'(strobes), 32'(cnt));
      chk("done_latency", 32'(last_strobe_cyc), 32'(cyc - 1));
      chk("busy_at_done", 32'(busy), 32'd0);
      cycles(1);
      chk("done_pulse", 32'(done), 32'd0);
    end
    t = 0;
    while (t < 8000 && (exp_words.size() != 0 || out_valid)) begin
      cycles(1);
      t++;
    end
    chk("words_left", 32'(exp_words.size()), 32'd0);
    chk("bursts_left", 32'(exp_bursts.size()), 32'd0);
  endtask

  initial begin
    vec_t tbl[6];
    int t;
    int dn;
    logic [22:0] ra;
    int rc;

    tbl[0] = '{23'h000000,   4, 0, 1,  3};
    tbl[1] = '{23'h0003F0,  10, 0, 2,  3};
    tbl[2] = '{23'h001000, 200, 0, 4, 63};
    tbl[3] = '{23'h7FFFF2,  10, 1, 2,  3};
    tbl[4] = '{23'h000104, 300, 1, 5, 63};
    tbl[5] = '{23'h0007FC,   1, 0, 1,  0};

    reset = 1'b1;
    start = 1'b0;
    start_address = '0;
    word_count = '0;
    cycles(2);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_req", 32'(rd_request), 32'd0);
    chk("rst_addr", 32'(rd_address), 32'd0);
    chk("rst_len", 32'(rd_burst_length), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    reset = 1'b0;
    cycles(2);

    for (int i = 0; i < 6; i++) begin
      ready_mode = tbl[i].mode;
      launch(tbl[i].a, tbl[i].cnt);
      if (tbl[i].cnt >= 50) begin
        cycles(3);
        poke_start();
      end
      finish_run(tbl[i].cnt);
      chk("nbursts", 32'(req_count), 32'(tbl[i].nb));
      chk("first_len", 32'(first_len), 32'(tbl[i].fl));
    end

    ready_mode = 0;
    launch(23'h000123, 0);
    finish_run(0);

    // Backpressure: the FIFO fills and no burst is issued without room.
    ready_mode = 2;
    cycles(2);
    launch(23'h000000, 300);
    t = 0;
    while (t < 3000 && strobes < DEPTH) begin
      cycles(1);
      t++;
    end
    cycles(40);
    chk("bp_strobes", 32'(strobes), 32'(DEPTH));
    chk("bp_reqs", 32'(req_count), 32'd2);
    chk("bp_busy", 32'(busy), 32'd1);
    chk("bp_valid", 32'(out_valid), 32'd1);
    ready_mode = 0;
    finish_run(300);
    chk("bp_total_reqs", 32'(req_count), 32'd5);

    // Reset in the middle of a burst abandons the run.
    launch(23'h000800, 100);
    t = 0;
    while (t < 1000 && strobes < 10) begin
      cycles(1);
      t++;
    end
    reset = 1'b1;
    cycles(1);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_req", 32'(rd_request), 32'd0);
    chk("mid_rst_addr", 32'(rd_address), 32'd0);
    chk("mid_rst_len", 32'(rd_burst_length), 32'd0);
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    reset = 1'b0;
    exp_words.delete();
    exp_bursts.delete();
    dn = 0;
    repeat (10) begin
      cycles(1);
      dn += int'(done);
    end
    chk("no_done_after_rst", 32'(dn), 32'd0);
    launch(23'h000200, 2);
    finish_run(2);
    chk("post_rst_reqs", 32'(req_count), 32'd1);

    for (int i = 0; i < 8; i++) begin
      ra = 23'($urandom);
      rc = $urandom_range(400, 1);
      ready_mode = $urandom_range(1);
      launch(ra, rc);
      if (rc >= 50) begin
        cycles(3);
        poke_start();
      end
      finish_run(rc);
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
